truth_table_sweeper: RTL

- Sequential stimulus/response engine for small combinational gates such as the 3-input OR, AND and NAND blocks in the guide exercises.
- Drives every input combination onto the device under test in ascending binary order and samples the device output after a programmable settle time.
- Assembles the measured truth table and compares it bit-by-bit against an expected table.
- Replaces the hand-written per-vector display benches with one synthesizable checker that every gate bench instantiates.

---
 rtl/truth_table_sweeper.sv | 128 ++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input vectors of a small gate, samples its response and checks it against a table
module truth_table_sweeper #(
   parameter int                  N_IN     = 3,
   parameter int                  SETTLE   = 1,
   parameter logic [2**N_IN-1:0]  EXPECTED = 8'hFE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [N_IN-1:0]      stim,
   input  logic                 resp,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   truth_table,
   output logic                 pass,
   output logic [N_IN:0]        mismatch_count,
   output logic [N_IN-1:0]      first_fail_idx
);
   localparam int NV = 2**N_IN;
   localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [NV-1:0]     tt_q, tt_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     mc_q, mc_d;
   logic [N_IN-1:0]   ffi_q, ffi_d;
   logic              sample, last, miss;

   assign sample = (state_q == RUN) && !abort && (wait_q == '0);
   assign last   = idx_q == N_IN'(NV - 1);
   assign miss   = resp != EXPECTED[idx_q];

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tt_q    <= '0;
         pass_q  <= 1'b0;
         mc_q    <= '0;
         ffi_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tt_q    <= tt_d;
         pass_q  <= pass_d;
         mc_q    <= mc_d;
         ffi_q   <= ffi_d;
      end
   end

   // next state: start launches a sweep, abort or the final sample returns to idle
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE)
         state_d = start ? RUN : IDLE;
      else
         state_d = (abort || (sample && last)) ? IDLE : RUN;
   end

   // datapath update: vector stepping, settle countdown, sampling and scoring
   always_comb begin
      idx_d  = idx_q;
      wait_d = wait_q;
      stim_d = stim_q;
      busy_d = busy_q;
      done_d = 1'b0;
      tt_d   = tt_q;
      pass_d = pass_q;
      mc_d   = mc_q;
      ffi_d  = ffi_q;
      if (state_q == IDLE) begin
         if (start) begin
            idx_d  = '0;
            stim_d = '0;
            wait_d = WW'(SETTLE);
            busy_d = 1'b1;
            tt_d   = '0;
            pass_d = 1'b0;
            mc_d   = '0;
            ffi_d  = '0;
         end
      end else if (abort) begin
         busy_d = 1'b0;
         stim_d = '0;
         pass_d = 1'b0;
      end else if (wait_q != '0) begin
         wait_d = wait_q - 1'b1;
      end else begin
         tt_d[idx_q] = resp;
         mc_d  = miss ? mc_q + 1'b1 : mc_q;
         ffi_d = (miss && mc_q == '0) ? idx_q : ffi_q;
         if (last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (mc_q == '0) && !miss;
         end else begin
            idx_d  = idx_q + 1'b1;
            stim_d = idx_q + 1'b1;
            wait_d = WW'(SETTLE);
         end
      end
   end

   assign stim           = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign truth_table    = tt_q;
   assign pass           = pass_q;
   assign mismatch_count = mc_q;
   assign first_fail_idx = ffi_q;
endmodule
